// File: rtl/alarm_puzzle_ctrl.sv
// Memory-sequence puzzle that silences an alarm: draws a random symbol sequence, shows it, checks button entries.
// Optional build macro PUZZLE_REPLAY_EN: after a failure the same sequence is replayed instead of drawing a new one.
module alarm_puzzle_ctrl #(
  parameter int SEQ_LEN        = 4,
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int GAP_CYCLES     = 10_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alm_Sound_In,
  input  logic [3:0] btn_Pulse,
  output logic [1:0] disp_Sym,
  output logic       disp_Valid,
  output logic [2:0] entry_Idx,
  output logic [3:0] fail_Cnt,
  output logic       puzzle_Solved
);

  localparam int MAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_B = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_B > SEQ_LEN) ? MAX_B : SEQ_LEN;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {IDLE, GEN, SHOW, GAP, ENTRY, FAIL, SOLVED} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [15:0]     lfsr;
  logic [1:0]      seq [0:7];
  logic            seq_we;
  logic [2:0]      seq_wa;
  logic [2:0]      idx_nx;
  logic            valid_nx;
  logic [1:0]      sym_nx;
  logic [3:0]      fail_nx;
  logic            btn_any, btn_multi;
  logic [1:0]      btn_sym;

  assign btn_any   = (btn_Pulse != 4'd0);
  assign btn_multi = ((btn_Pulse & (btn_Pulse - 4'd1)) != 4'd0);

  // Encode a one-hot button pulse into its symbol index
  always_comb begin
    case (btn_Pulse)
      4'b0010: btn_sym = 2'd1;
      4'b0100: btn_sym = 2'd2;
      4'b1000: btn_sym = 2'd3;
      default: btn_sym = 2'd0;
    endcase
  end

  // Next-state and next-output decode; an alarm drop overrides every other event
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = entry_Idx;
    valid_nx = 1'b0;
    sym_nx   = 2'd0;
    fail_nx  = fail_Cnt;
    seq_we   = 1'b0;
    seq_wa   = 3'(cnt);
    case (state)
      IDLE: begin
        if (alm_Sound_In) begin
          state_nx = GEN;
          cnt_nx   = CW'(0);
          fail_nx  = 4'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      SOLVED: begin
        if (!alm_Sound_In) begin
          state_nx = IDLE;
        end else begin
          state_nx = SOLVED;
        end
      end
      default: begin
        if (!alm_Sound_In) begin
          state_nx = IDLE;
          cnt_nx   = CW'(0);
          idx_nx   = 3'd0;
        end else begin
          case (state)
            GEN: begin
              seq_we = 1'b1;
              if (cnt == CW'(SEQ_LEN - 1)) begin
                state_nx = SHOW;
                cnt_nx   = CW'(0);
                idx_nx   = 3'd0;
                valid_nx = 1'b1;
                sym_nx   = seq[0];
              end else begin
                cnt_nx = cnt + CW'(1);
              end
            end
            SHOW: begin
              if (cnt == CW'(SHOW_CYCLES - 1)) begin
                state_nx = GAP;
                cnt_nx   = CW'(0);
              end else begin
                cnt_nx   = cnt + CW'(1);
                valid_nx = 1'b1;
                sym_nx   = disp_Sym;
              end
            end
            GAP: begin
              if (cnt != CW'(GAP_CYCLES - 1)) begin
                cnt_nx = cnt + CW'(1);
              end else if (entry_Idx < 3'(SEQ_LEN - 1)) begin
                state_nx = SHOW;
                cnt_nx   = CW'(0);
                idx_nx   = entry_Idx + 3'd1;
                valid_nx = 1'b1;
                sym_nx   = seq[entry_Idx + 3'd1];
              end else begin
                state_nx = ENTRY;
                cnt_nx   = CW'(0);
                idx_nx   = 3'd0;
              end
            end
            ENTRY: begin
              // A press is evaluated before the timeout so a press on the final cycle wins
              if (btn_any) begin
                if (!btn_multi && (btn_sym == seq[entry_Idx])) begin
                  cnt_nx = CW'(0);
                  if (entry_Idx == 3'(SEQ_LEN - 1)) begin
                    state_nx = SOLVED;
                  end else begin
                    idx_nx = entry_Idx + 3'd1;
                  end
                end else begin
                  state_nx = FAIL;
                end
              end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                state_nx = FAIL;
              end else begin
                cnt_nx = cnt + CW'(1);
              end
            end
            FAIL: begin
              fail_nx = (fail_Cnt == 4'd15) ? 4'd15 : (fail_Cnt + 4'd1);
              idx_nx  = 3'd0;
              cnt_nx  = CW'(0);
`ifdef PUZZLE_REPLAY_EN
              state_nx = SHOW;
              valid_nx = 1'b1;
              sym_nx   = seq[0];
`else
              state_nx = GEN;
`endif
            end
            default: begin
              state_nx = IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // State, counter, LFSR, sequence storage and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= CW'(0);
      lfsr          <= 16'hACE1;
      disp_Sym      <= 2'd0;
      disp_Valid    <= 1'b0;
      entry_Idx     <= 3'd0;
      fail_Cnt      <= 4'd0;
      puzzle_Solved <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        seq[i] <= 2'd0;
      end
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      disp_Sym      <= sym_nx;
      disp_Valid    <= valid_nx;
      entry_Idx     <= idx_nx;
      fail_Cnt      <= fail_nx;
      puzzle_Solved <= (state == SOLVED);
      if (seq_we) begin
        seq[seq_wa] <= lfsr[1:0];
      end else begin
        seq[seq_wa] <= seq[seq_wa];
      end
    end
  end

endmodule

// File: tb/tb_alarm_puzzle_ctrl.sv
// Directed self-checking bench for alarm_puzzle_ctrl with small timing parameters.
module tb_alarm_puzzle_ctrl;

  localparam int SL = 4;
  localparam int SH = 4;
  localparam int GP = 2;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       alm_Sound_In;
  logic [3:0] btn_Pulse;
  logic [1:0] disp_Sym;
  logic       disp_Valid;
  logic [2:0] entry_Idx;
  logic [3:0] fail_Cnt;
  logic       puzzle_Solved;

  int checks = 0;
  int passes = 0;
  int cyc;
  logic [7:0] cur_seq;

  alarm_puzzle_ctrl #(
    .SEQ_LEN(SL), .SHOW_CYCLES(SH), .GAP_CYCLES(GP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .alm_Sound_In(alm_Sound_In), .btn_Pulse(btn_Pulse),
    .disp_Sym(disp_Sym), .disp_Valid(disp_Valid), .entry_Idx(entry_Idx),
    .fail_Cnt(fail_Cnt), .puzzle_Solved(puzzle_Solved)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the LFSR has advanced exactly this many times
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Sequence drawn by a GEN phase entered on edge g: symbol i is lfsr bits [1:0] after g+i steps
  function automatic logic [7:0] gen_exp(input int g);
    logic [15:0] l;
    logic [7:0]  s;
    l = 16'hACE1;
    s = 8'd0;
    for (int n = 0; n < g; n++) l = lfsr_step(l);
    for (int i = 0; i < SL; i++) begin
      s[2*i +: 2] = l[1:0];
      l = lfsr_step(l);
    end
    return s;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts right after the edge entering the first SHOW; ends right after the edge entering ENTRY
  task automatic show_phase(input bit inject);
    for (int i = 0; i < SL; i++) begin
      for (int k = 0; k < SH; k++) begin
        checks++; if (disp_Valid !== 1'b1) $display("FAIL show_valid: got %b want 1 (i=%0d k=%0d)", disp_Valid, i, k); else passes++;
        checks++; if (disp_Sym !== cur_seq[2*i +: 2]) $display("FAIL show_sym: got %0d want %0d (i=%0d)", disp_Sym, cur_seq[2*i +: 2], i); else passes++;
        checks++; if (entry_Idx !== 3'(i)) $display("FAIL show_idx: got %0d want %0d", entry_Idx, i); else passes++;
        if (inject && k == 1) btn_Pulse = onehot(cur_seq[2*i +: 2]);
        tick();
        btn_Pulse = 4'd0;
      end
      for (int k = 0; k < GP; k++) begin
        checks++; if (disp_Valid !== 1'b0) $display("FAIL gap_valid: got %b want 0 (i=%0d)", disp_Valid, i); else passes++;
        checks++; if (entry_Idx !== 3'(i)) $display("FAIL gap_idx: got %0d want %0d", entry_Idx, i); else passes++;
        if (inject && k == 0) btn_Pulse = 4'b1111;
        tick();
        btn_Pulse = 4'd0;
      end
    end
    checks++; if (disp_Valid !== 1'b0) $display("FAIL entry_valid: got %b want 0", disp_Valid); else passes++;
    checks++; if (entry_Idx !== 3'd0) $display("FAIL entry_idx0: got %0d want 0", entry_Idx); else passes++;
  endtask

  // Called right after the edge that enters FAIL
  task automatic after_fail(input logic [3:0] want_fail, input bit inject);
    tick();
    checks++; if (fail_Cnt !== want_fail) $display("FAIL fail_cnt: got %0d want %0d", fail_Cnt, want_fail); else passes++;
    checks++; if (entry_Idx !== 3'd0) $display("FAIL fail_idx: got %0d want 0", entry_Idx); else passes++;
`ifndef PUZZLE_REPLAY_EN
    cur_seq = gen_exp(cyc);
    repeat (SL) begin
      checks++; if (disp_Valid !== 1'b0) $display("FAIL regen_valid: got %b want 0", disp_Valid); else passes++;
      tick();
    end
`endif
    show_phase(inject);
  endtask

  task automatic press_ok(input int i);
    btn_Pulse = onehot(cur_seq[2*i +: 2]);
    tick();
    btn_Pulse = 4'd0;
    checks++; if (entry_Idx !== 3'(i + 1)) $display("FAIL press_idx: got %0d want %0d", entry_Idx, i + 1); else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b0; alm_Sound_In = 1'b1; btn_Pulse = 4'd0;
    repeat (3) tick();
    checks++; if (disp_Valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", disp_Valid); else passes++;
    checks++; if (disp_Sym !== 2'd0) $display("FAIL rst_sym: got %0d want 0", disp_Sym); else passes++;
    checks++; if (entry_Idx !== 3'd0) $display("FAIL rst_idx: got %0d want 0", entry_Idx); else passes++;
    checks++; if (fail_Cnt !== 4'd0) $display("FAIL rst_fail: got %0d want 0", fail_Cnt); else passes++;
    checks++; if (puzzle_Solved !== 1'b0) $display("FAIL rst_solved: got %b want 0", puzzle_Solved); else passes++;
    rst = 1'b1;
    tick();
    cur_seq = gen_exp(1);
    repeat (SL - 1) begin
      checks++; if (disp_Valid !== 1'b0) $display("FAIL gen_latency: got %b want 0", disp_Valid); else passes++;
      tick();
    end
    checks++; if (disp_Valid !== 1'b0) $display("FAIL gen_latency_last: got %b want 0", disp_Valid); else passes++;
    tick();
    show_phase(1'b0);
  endtask

  task automatic test_correct();
    for (int i = 0; i < SL - 1; i++) press_ok(i);
    btn_Pulse = onehot(cur_seq[2*(SL-1) +: 2]);
    tick();
    btn_Pulse = 4'd0;
    checks++; if (puzzle_Solved !== 1'b0) $display("FAIL solved_early: got %b want 0", puzzle_Solved); else passes++;
    tick();
    checks++; if (puzzle_Solved !== 1'b1) $display("FAIL solved_set: got %b want 1", puzzle_Solved); else passes++;
    repeat (3) tick();
    checks++; if (puzzle_Solved !== 1'b1) $display("FAIL solved_hold: got %b want 1", puzzle_Solved); else passes++;
    checks++; if (entry_Idx !== 3'(SL - 1)) $display("FAIL solved_idx: got %0d want %0d", entry_Idx, SL - 1); else passes++;
    alm_Sound_In = 1'b0;
    tick();
    checks++; if (puzzle_Solved !== 1'b1) $display("FAIL drop_solved1: got %b want 1", puzzle_Solved); else passes++;
    tick();
    checks++; if (puzzle_Solved !== 1'b0) $display("FAIL drop_solved2: got %b want 0", puzzle_Solved); else passes++;
    repeat (2) tick();
  endtask

  task automatic test_wrong_symbol();
    alm_Sound_In = 1'b1;
    tick();
    checks++; if (fail_Cnt !== 4'd0) $display("FAIL gen_fail_clr: got %0d want 0", fail_Cnt); else passes++;
    cur_seq = gen_exp(cyc);
    repeat (SL) tick();
    show_phase(1'b0);
    press_ok(0);
    btn_Pulse = onehot(cur_seq[3:2] + 2'd1);
    tick();
    btn_Pulse = 4'd0;
    after_fail(4'd1, 1'b0);
  endtask

  task automatic test_timeout_multihot();
    repeat (TO - 1) tick();
    checks++; if (fail_Cnt !== 4'd1) $display("FAIL pre_timeout: got %0d want 1", fail_Cnt); else passes++;
    tick();
    after_fail(4'd2, 1'b0);
    repeat (TO - 1) tick();
    press_ok(0);
    tick();
    checks++; if (fail_Cnt !== 4'd2) $display("FAIL press_beats_timeout: got %0d want 2", fail_Cnt); else passes++;
    checks++; if (entry_Idx !== 3'd1) $display("FAIL press_beats_timeout_idx: got %0d want 1", entry_Idx); else passes++;
    btn_Pulse = 4'b0011;
    tick();
    btn_Pulse = 4'd0;
    after_fail(4'd3, 1'b0);
    for (int n = 4; n <= 16; n++) begin
      btn_Pulse = 4'b0011;
      tick();
      btn_Pulse = 4'd0;
      after_fail((n > 15) ? 4'd15 : 4'(n), (n == 5));
    end
  endtask

  task automatic test_collisions();
    for (int i = 0; i < SL - 1; i++) press_ok(i);
    btn_Pulse = onehot(cur_seq[2*(SL-1) +: 2]);
    alm_Sound_In = 1'b0;
    tick();
    btn_Pulse = 4'd0;
    checks++; if (entry_Idx !== 3'd0) $display("FAIL coll_idx: got %0d want 0", entry_Idx); else passes++;
    tick();
    checks++; if (puzzle_Solved !== 1'b0) $display("FAIL coll_solved: got %b want 0", puzzle_Solved); else passes++;
    checks++; if (fail_Cnt !== 4'd15) $display("FAIL coll_fail_hold: got %0d want 15", fail_Cnt); else passes++;
    alm_Sound_In = 1'b1;
    tick();
    checks++; if (fail_Cnt !== 4'd0) $display("FAIL rearm_fail_clr: got %0d want 0", fail_Cnt); else passes++;
    repeat (SL) tick();
    checks++; if (disp_Valid !== 1'b1) $display("FAIL rearm_show: got %b want 1", disp_Valid); else passes++;
    repeat (2) tick();
    alm_Sound_In = 1'b0;
    tick();
    checks++; if (disp_Valid !== 1'b0) $display("FAIL mid_show_drop_valid: got %b want 0", disp_Valid); else passes++;
    checks++; if (entry_Idx !== 3'd0) $display("FAIL mid_show_drop_idx: got %0d want 0", entry_Idx); else passes++;
    repeat (3) tick();
    checks++; if (disp_Valid !== 1'b0) $display("FAIL idle_stays: got %b want 0", disp_Valid); else passes++;
    checks++; if (puzzle_Solved !== 1'b0) $display("FAIL idle_solved: got %b want 0", puzzle_Solved); else passes++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong_symbol();
    test_timeout_multihot();
    test_collisions();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
